serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- Receiving end of the team's bit-serial word link. It does the time-domain equivalent of DMUX: it distributes one serial line over the WIDTH bit positions of a parallel word.
- Frame format: idle-high line, one start bit (0), WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Delivers each word to the LittleComputer core through a VALID/READY register interface.

Parameters:
- WIDTH, 16, data bits per frame (matches the machine word).
- CYCLES_PER_BIT, 4, clock cycles per serial bit; must be an even number ≥ 2. HALF = CYCLES_PER_BIT/2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- SIN  input  1  serial line, already synchronised to CLK, idle = 1.
- Y  output  WIDTH  last received word.
- VALID  output  1  Y holds an unconsumed word.
- READY  input  1  consumer accepts Y when VALID & READY.
- FERR  output  1  sticky framing error (stop bit sampled 0).
- OVR  output  1  sticky overrun (word dropped because Y was still occupied).

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. RST overrides all other inputs.
- Reset values: state=IDLE; Y=0; VALID=0; FERR=0; OVR=0; bit timer=0; bit index=0; shift register=0.
- Reset mid-frame abandons the frame with no error flagged.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - SIN=0 sampled at cycle t0 -> START, timer cleared.
- START:
  - At t0+HALF, SIN is resampled.
  - SIN=0 -> DATA, timer cleared, bit index 0.
  - SIN=1 -> false start, return to IDLE with no flags.
- DATA:
  - Bit i is sampled at t0+HALF+(i+1)*CYCLES_PER_BIT.
  - Each sample shifts into the MSB of the shift register, so after WIDTH samples bit 0 sits in the LSB.
  - After bit WIDTH-1 -> STOP.
- STOP:
  - Sampled at t0+HALF+(WIDTH+1)*CYCLES_PER_BIT.
  - SIN=1 -> deliver the word, then IDLE.
  - SIN=0 -> FERR<=1, word discarded, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stays until SIN=1 is sampled, then IDLE. This prevents a break condition from being read as a start bit.
- Delivery (cycle after the stop sample):
  - If VALID=0, or VALID&READY in that same cycle: Y<=word and VALID=1.
  - Otherwise: Y unchanged, OVR<=1, word dropped.
- Handshake:
  - VALID&READY with no delivery that cycle -> VALID=0 next cycle.
  - Y holds its value while VALID=0.
- Latency:
  - VALID rises at t0+HALF+(WIDTH+1)*CYCLES_PER_BIT+1.
  - With defaults (HALF=2, WIDTH=16, CYCLES_PER_BIT=4), VALID rises at t0+71.
- Back-to-back frames:
  - A new start bit is accepted the first IDLE cycle after the stop sample.
  - The minimum frame period is (WIDTH+2)*CYCLES_PER_BIT cycles.
- FERR and OVR are sticky until RST.
- Glitches on SIN between sample points are ignored.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit; even parity over data+parity is expected.
  - Adds output PERR (1 bit, reset 0, sticky).
  - On mismatch: PERR<=1 and the word is still delivered.
  - Stop sample moves to t0+HALF+(WIDTH+2)*CYCLES_PER_BIT.
- Undefined: no PARITY state, no PERR port, timing as stated above.

Decomposition:
- Shared package little_computer_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE, PARITY.
  - Constant WORD_WIDTH=16.
  - Constant SERIAL_IDLE_LEVEL=1'b1.
- Sub-module bit_timer:
  - Modulo-CYCLES_PER_BIT counter with synchronous clear.
  - Outputs a half-tick and a full-tick pulse.
  - Reused by the matching transmitter.

Test Plan:
- Frame 0xA5C3 at defaults, READY=1 -> VALID pulses 1 cycle at t0+71, Y=0xA5C3, FERR=0, OVR=0.
- 1-cycle SIN low pulse in IDLE (false start) -> state returns to IDLE at t0+2, no VALID, no flags; next valid frame 0x0001 received correctly.
- Frame 0x1234 with stop bit forced 0, SIN held 0 for 10 more bit times -> FERR=1, VALID stays 0, no spurious frame; then frame 0x5678 -> Y=0x5678.
- Two back-to-back frames 0x1111, 0x2222 with READY=0 -> Y=0x1111, VALID=1, OVR=1 after second stop bit; assert READY -> VALID falls next cycle, Y stays 0x1111.
- READY=1 in the exact delivery cycle of the second frame while VALID=1 -> Y=0x2222, VALID stays 1, OVR=0.
- RST asserted at data bit 7 of frame 0xFFFF, released, then frame 0x00F0 sent -> all outputs 0 during reset, Y=0x00F0 after, no flags; with SERIAL_RX_PARITY_EN, 0x0003 sent with bad parity -> PERR=1, Y=0x0003.

Source files
------------

// File: rtl/little_computer_pkg.sv
// Shared definitions for the LittleComputer serial link.
//   rx_state_t        : receiver frame states
//   WORD_WIDTH        : machine word width
//   SERIAL_IDLE_LEVEL : line level between frames
package little_computer_pkg;

  localparam int   WORD_WIDTH        = 16;
  localparam logic SERIAL_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE,
    PARITY
  } rx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Modulo-CYCLES_PER_BIT cycle counter shared by the serial receiver and
// transmitter. half_tick marks the middle of a bit cell measured from the
// last clear, full_tick marks one whole bit period later, and every
// CYCLES_PER_BIT cycles after that.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   clr       : synchronous clear, counter reads 0 next cycle
//   half_tick : counter == CYCLES_PER_BIT/2 - 1
//   full_tick : counter == CYCLES_PER_BIT - 1
module bit_timer #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr || (cnt_q == LAST)) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign half_tick = (cnt_q == HALF_M1);
  assign full_tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_receiver.sv
// Bit-serial word receiver: start bit, WIDTH data bits LSB first, optional
// even parity bit, stop bit. Completed words are handed to the core through
// a VALID/READY register.
// Optional feature: define SERIAL_RX_PARITY_EN to add the parity bit and the
// sticky PERR output.
// Ports:
//   CLK   : system clock, rising edge
//   RST   : synchronous active-high reset
//   SIN   : serial line, synchronised to CLK, idle high
//   Y     : last received word
//   VALID : Y holds an unconsumed word
//   READY : consumer takes Y when VALID & READY
//   FERR  : sticky framing error (stop bit sampled low)
//   OVR   : sticky overrun (word dropped, Y still occupied)
//   PERR  : sticky parity error (only with SERIAL_RX_PARITY_EN)
//
// state     | meaning
// IDLE      | line idle, timer held clear, waiting for a low sample
// START     | confirming the start bit at its midpoint
// DATA      | sampling data bits at bit-cell midpoints
// PARITY    | sampling the parity bit (parity builds only)
// STOP      | sampling the stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module serial_word_receiver
  import little_computer_pkg::*;
#(
  parameter int WIDTH          = WORD_WIDTH,
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  output logic [WIDTH-1:0] Y,
  output logic             VALID,
  input  logic             READY,
  output logic             FERR,
  output logic             OVR
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic             PERR
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             deliver_q, deliver_d;
`ifdef SERIAL_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif
  logic             timer_clr;
  logic             half_tick;
  logic             full_tick;

  bit_timer #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_bit_timer (
    .clk       (CLK),
    .rst       (RST),
    .clr       (timer_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    y_d       = y_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    deliver_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d    = perr_q;
`endif
    timer_clr = 1'b0;

    case (state_q)
      IDLE: begin
        // Holding the timer clear makes the first half_tick land HALF
        // cycles after the falling edge was sampled.
        timer_clr = 1'b1;
        if (SIN != SERIAL_IDLE_LEVEL) state_d = START;
      end
      START: begin
        if (half_tick) begin
          if (SIN == 1'b0) begin
            state_d   = DATA;
            idx_d     = '0;
            timer_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d = {SIN, shift_q[WIDTH-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (full_tick) begin
          // Even parity: data plus parity bit must XOR to zero.
          if (^{shift_q, SIN}) perr_d = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (full_tick) begin
          if (SIN == 1'b1) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (SIN == SERIAL_IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The shift register is untouched in IDLE, so it still holds the word
    // one cycle after the stop sample even if a new start bit arrives.
    if (deliver_q) begin
      if (!valid_q || READY) begin
        y_d     = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      deliver_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      deliver_q <= deliver_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver: directed frames plus a randomized run,
// with a frame-level reference model feeding a scoreboard.
module tb_serial_word_receiver;

  localparam int W    = 16;
  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Serial frame length on the wire and start-sample-to-VALID latency.
  localparam int FRAME_LEN = (W + 2 + PBITS) * CPB;
  localparam int LAT       = HALF + (W + 1 + PBITS) * CPB + 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         SIN = 1'b1;
  logic         READY = 1'b1;
  logic [W-1:0] Y;
  logic         VALID;
  logic         FERR;
  logic         OVR;
`ifdef SERIAL_RX_PARITY_EN
  logic         PERR;
  bit           bad_par_next = 1'b0;
  bit           m_perr = 1'b0;
`endif

  serial_word_receiver #(.WIDTH(W), .CYCLES_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SIN   (SIN),
    .Y     (Y),
    .VALID (VALID),
    .READY (READY),
    .FERR  (FERR),
    .OVR   (OVR)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .PERR  (PERR)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         d;
    logic [W-1:0] w;
  } item_t;

  item_t pend_q[$];   // complete frames on the wire, awaiting delivery
  item_t exp_q[$];    // words the DUT must present, with presentation cycle

  bit m_valid = 1'b0;
  bit m_ovr   = 1'b0;
  bit m_ferr  = 1'b0;
  int n_vec   = 0;
  int n_err   = 0;
  bit rand_ready = 1'b0;
  int pulse_at   = -10;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: a word arriving while the holding register is occupied
  // and not being drained in that cycle is lost and raises the overrun flag.
  initial begin
    item_t it;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pend_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        m_perr  = 1'b0;
`endif
      end else if (pend_q.size() > 0 && pend_q[0].d == cyc + 1) begin
        it = pend_q.pop_front();
        if (!m_valid || READY) begin
          m_valid = 1'b1;
          exp_q.push_back(it);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && READY) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: a new word is on Y whenever VALID is seen high after it was low
  // or after the previous word was taken.
  initial begin
    item_t it;
    bit pv;
    bit ph;
    pv = 1'b0;
    ph = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        if (VALID && (!pv || ph)) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got Y=0x%0h, expected no word (cycle %0d)", Y, cyc);
          end else begin
            it = exp_q.pop_front();
            check("word_value", Y, it.w);
            check("word_latency", cyc, it.d);
          end
        end
        pv = VALID;
        ph = VALID && READY;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ready) READY = ($urandom_range(0, 99) < 3);
    if (cyc == pulse_at - 1) READY = 1'b1;
    else if (cyc == pulse_at) READY = 1'b0;
  endtask

  task automatic idle(input int n);
    SIN = 1'b1;
    repeat (n) tick();
  endtask

  // Sends start + nbits data bits; a full frame (nbits == W) also gets its
  // parity bit (if built) and a stop bit.
  task automatic send_frame(input logic [W-1:0] w, input bit stop_ok, input int nbits);
    item_t it;
    if (nbits == W && stop_ok) begin
      it.d = cyc + 1 + LAT;
      it.w = w;
      pend_q.push_back(it);
    end
    if (nbits == W && !stop_ok) m_ferr = 1'b1;
    SIN = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < nbits; i++) begin
      SIN = w[i];
      repeat (CPB) tick();
    end
    if (nbits == W) begin
`ifdef SERIAL_RX_PARITY_EN
      if (bad_par_next) m_perr = 1'b1;
      SIN = (^w) ^ bad_par_next;
      repeat (CPB) tick();
`endif
      SIN = stop_ok;
      repeat (CPB) tick();
      SIN = 1'b1;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ferr"}, FERR, m_ferr);
    check({tag, "_ovr"}, OVR, m_ovr);
`ifdef SERIAL_RX_PARITY_EN
    check({tag, "_perr"}, PERR, m_perr);
`endif
  endtask

  initial begin
    logic [W-1:0] w;
    bit ok;

    RST = 1'b1;
    SIN = 1'b1;
    READY = 1'b1;
    repeat (3) tick();
    check("reset_y", Y, 0);
    check("reset_valid", VALID, 0);
    check("reset_ferr", FERR, 0);
    check("reset_ovr", OVR, 0);
    RST = 1'b0;
    idle(2 * CPB);

    // Plain frame, consumer always ready.
    send_frame(16'hA5C3, 1'b1, W);
    idle(2 * CPB);
    check("t1_y", Y, 16'hA5C3);
    check("t1_valid_pulse", VALID, 0);
    check_flags("t1");

    // One-cycle low glitch while idle.
    SIN = 1'b0;
    tick();
    idle(3 * CPB);
    check("t2_valid", VALID, 0);
    check_flags("t2");
    send_frame(16'h0001, 1'b1, W);
    idle(2 * CPB);
    check("t2_y", Y, 16'h0001);

    // Stop bit low followed by a long break.
    send_frame(16'h1234, 1'b0, W);
    SIN = 1'b0;
    repeat (10 * CPB) tick();
    check("t3_valid", VALID, 0);
    idle(2 * CPB);
    check("t3_ferr", FERR, 1);
    check_flags("t3");
    send_frame(16'h5678, 1'b1, W);
    idle(2 * CPB);
    check("t3_y", Y, 16'h5678);

    // Back-to-back frames with the consumer stalled.
    READY = 1'b0;
    send_frame(16'h1111, 1'b1, W);
    send_frame(16'h2222, 1'b1, W);
    check("t4_y", Y, 16'h1111);
    check("t4_valid", VALID, 1);
    check("t4_ovr", OVR, 1);
    READY = 1'b1;
    tick();
    check("t4_valid_drop", VALID, 0);
    check("t4_y_hold", Y, 16'h1111);

    // READY raised exactly in the second delivery cycle.
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    idle(CPB);
    READY = 1'b0;
    pulse_at = cyc + 1 + FRAME_LEN + LAT;
    send_frame(16'h1111, 1'b1, W);
    send_frame(16'h2222, 1'b1, W);
    check("t5_y", Y, 16'h2222);
    check("t5_valid", VALID, 1);
    check("t5_ovr", OVR, 0);
    pulse_at = -10;
    READY = 1'b1;
    tick();
    check("t5_valid_drop", VALID, 0);

    // Reset in the middle of a frame.
    send_frame(16'hFFFF, 1'b1, 7);
    SIN = 1'b1;
    RST = 1'b1;
    repeat (2) tick();
    check("t6_rst_y", Y, 0);
    check("t6_rst_valid", VALID, 0);
    check("t6_rst_ferr", FERR, 0);
    check("t6_rst_ovr", OVR, 0);
    RST = 1'b0;
    idle(2 * CPB);
    send_frame(16'h00F0, 1'b1, W);
    idle(2 * CPB);
    check("t6_y", Y, 16'h00F0);
    check("t6_ferr", FERR, 0);
    check("t6_ovr", OVR, 0);

`ifdef SERIAL_RX_PARITY_EN
    bad_par_next = 1'b1;
    send_frame(16'h0003, 1'b1, W);
    bad_par_next = 1'b0;
    idle(2 * CPB);
    check("t7_perr", PERR, 1);
    check("t7_y", Y, 16'h0003);
`endif

    // Randomized frames with a mostly stalled consumer.
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      w  = W'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(w, ok, W);
      if (!ok) idle(CPB);
      idle($urandom_range(0, 2) * CPB);
    end
    rand_ready = 1'b0;
    READY = 1'b1;
    idle(LAT + 4 * CPB);
    check("queue_drained", exp_q.size() + pend_q.size(), 0);
    check_flags("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
